// File: rtl/player_display_ctrl_pkg.sv
// Shared definitions for the player-turn display controller.
//   - Display codes consumed by the downstream seven_segment decoders.
//   - FSM state encoding.
//   - Small helpers for player validation and digit formatting.
package player_display_ctrl_pkg;

    localparam logic [3:0] CODE_BLANK = 4'hE;
    localparam logic [3:0] CODE_P     = 4'hF;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHOW_ENC  = 2'd1;
    localparam logic [1:0] ST_BLINK_ENC = 2'd2;
    localparam logic [1:0] ST_HOLD_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHOW  = ST_SHOW_ENC,
        ST_BLINK = ST_BLINK_ENC,
        ST_HOLD  = ST_HOLD_ENC
    } state_t;

    // Player 3 does not exist; a load carrying it is discarded entirely.
    function automatic logic player_valid(input logic [1:0] p);
        return (p != 2'b11);
    endfunction

    function automatic logic [3:0] digit_code(input logic [1:0] p);
        return {2'b00, p};
    endfunction

endpackage

// File: rtl/player_display_ctrl_if.sv
// Command/display bundle between a game controller and player_display_ctrl.
//   load, player, win, clear : one-cycle command strobes (controller -> display ctrl)
//   hex1, hex0               : left/right digit codes for the seven_segment decoders
//   busy                     : high while the win announcement is blinking
interface player_display_ctrl_if;
    logic       load;
    logic [1:0] player;
    logic       win;
    logic       clear;
    logic [3:0] hex1;
    logic [3:0] hex0;
    logic       busy;

    modport master (
        output load, player, win, clear,
        input  hex1, hex0, busy
    );

    modport slave (
        input  load, player, win, clear,
        output hex1, hex0, busy
    );
endinterface

// File: rtl/player_display_ctrl_tick_prescaler.sv
// Blink-phase prescaler.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable; low synchronously returns the count to 0
//   tick  : one-cycle pulse while the count sits at its terminal value TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Not gated by en: the count is parked at 0 while disabled and
    // TICK_DIV >= 2, so the terminal value is only reachable while enabled.
    // Keeping en out of this path avoids a loop through the parent's FSM.
    assign tick = (cnt == TERM);

endmodule

// File: rtl/player_display_ctrl.sv
// Player-turn indicator driving two seven_segment decoders.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of player_display_ctrl_if (strobes in, hex1/hex0/busy out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | both digits blank, waiting for a valid load
// SHOW  | "P<n>" shown for the latched player
// BLINK | win announcement: display toggles each tick, busy=1
// HOLD  | announcement finished, "P<n>" held steadily
module player_display_ctrl
    import player_display_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = 25_000_000,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    player_display_ctrl_if.slave  bus
);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);
    localparam logic [TW-1:0] LAST_TOGGLE = TW'(BLINK_TOGGLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    player_q, player_d;
    logic          shown_q, shown_d;
    logic [TW-1:0] toggle_q, toggle_d;
    logic [3:0]    hex1_q, hex0_q;
    logic          busy_q;
    logic          tick;
    logic          tick_en;
    logic          load_ok;

    // Enabled only while staying in BLINK, so the count is 0 on the entry
    // edge and is returned to 0 on the very edge BLINK is left.
    assign tick_en = (state_q == ST_BLINK) && (state_d == ST_BLINK);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .tick  (tick)
    );

    // Priority clear > win > load: a win in the same cycle drops the load
    // even in states where the win itself has no effect.
    assign load_ok = bus.load && !bus.win && player_valid(bus.player);

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        shown_d  = shown_q;
        toggle_d = toggle_q;

        if (bus.clear) begin
            state_d  = ST_IDLE;
            shown_d  = 1'b0;
            toggle_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (load_ok) begin
                        state_d  = ST_SHOW;
                        player_d = bus.player;
                        shown_d  = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (bus.win) begin
                        state_d  = ST_BLINK;
                        shown_d  = 1'b0;
                        toggle_d = '0;
                    end else if (load_ok) begin
                        player_d = bus.player;
                    end
                end
                ST_BLINK: begin
                    if (tick) begin
                        if (toggle_q == LAST_TOGGLE) begin
                            // Final toggle always lands on "shown", whatever the parity.
                            state_d  = ST_HOLD;
                            shown_d  = 1'b1;
                            toggle_d = '0;
                        end else begin
                            toggle_d = toggle_q + 1'b1;
                            shown_d  = !shown_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    shown_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            player_q <= 2'd0;
            shown_q  <= 1'b0;
            toggle_q <= '0;
            hex1_q   <= CODE_BLANK;
            hex0_q   <= CODE_BLANK;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            shown_q  <= shown_d;
            toggle_q <= toggle_d;
            hex1_q   <= shown_d ? CODE_P : CODE_BLANK;
            hex0_q   <= shown_d ? digit_code(player_d) : CODE_BLANK;
            busy_q   <= (state_d == ST_BLINK);
        end
    end

    assign bus.hex1 = hex1_q;
    assign bus.hex0 = hex0_q;
    assign bus.busy = busy_q;

endmodule

// File: doc/player_display_ctrl.md
Name: player_display_ctrl

Overview:
- Upstream driver for two seven_segment decoder instances on the DE2 HEX displays.
- Produces 4-bit display codes for a player-turn indicator:
  - "P<n>" shows whose turn it is.
  - A win announcement blinks "P<n>" and then holds it steadily.
  - Otherwise both digits are blank.
- Code map consumed downstream: 0x0-0x2 = digits, 0xE = blank, 0xF = "P".

Parameters:
- TICK_DIV, 25_000_000, clk cycles per blink phase (0.5 s at 50 MHz); must be >= 2.
- BLINK_TOGGLES, 6, number of blink-phase ticks before entering HOLD; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe: latch player as the current player.
- player  in  2  player number, valid values 0..2; sampled when load=1.
- win  in  1  one-cycle strobe: announce the current player as winner.
- clear  in  1  one-cycle strobe: return to blank display.
- hex1  out  4  left-digit code, drives seven_segment.i.
- hex0  out  4  right-digit code, drives seven_segment.i.
- busy  out  1  high while blinking.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, hex1=4'hE, hex0=4'hE, busy=0.
  - Tick counter = 0, toggle counter = 0, latched player = 0.
  - Takes effect immediately, including mid-blink.
- All outputs are registered. Every response appears on the clock edge after the strobe (latency 1).
- States: IDLE, SHOW, BLINK, HOLD.
- Display contents:
  - "shown" = hex1=4'hF, hex0={2'b00, latched player}.
  - "blank" = hex1=hex0=4'hE.
- IDLE: blank, busy=0.
  - load with valid player -> SHOW.
  - win -> ignored.
- SHOW: shown, busy=0.
  - load with valid player -> stay in SHOW with the new player.
  - win -> BLINK.
- BLINK: busy=1.
  - Entry: tick counter=0, toggle counter=0, display goes blank on the entry edge.
  - Tick counter runs 0..TICK_DIV-1 and wraps to 0. Its terminal value is the tick.
  - On each tick: toggle counter +1 and the display toggles blank/shown.
  - On the tick where toggle counter reaches BLINK_TOGGLES: go to HOLD with display shown, regardless of phase parity.
  - load and win are ignored.
- HOLD: shown, busy=0.
  - load with valid player -> SHOW with the new player.
  - win -> ignored.
- Invalid player (player==2'b11) on load: the whole load is ignored (no latch, no state change).
- clear: from any state -> IDLE, blank, busy=0. Latched player is preserved.
- Simultaneous strobes: priority is clear > win > load. A lower-priority strobe in the same cycle is dropped.
- Tick counter counts only in BLINK and is held at 0 in all other states.
- Counter widths: $clog2(TICK_DIV) bits for the tick counter, $clog2(BLINK_TOGGLES+1) bits for the toggle counter. No overflow is reachable.

Decomposition:
- Shared package/header holds:
  - display code constants: CODE_BLANK=4'hE, CODE_P=4'hF;
  - state encoding localparams for IDLE, SHOW, BLINK, HOLD.
- One sub-module: tick_prescaler.
  - Parameter: TICK_DIV.
  - Ports: clk, rst_n, en, tick.
  - en=0 synchronously clears the count.
  - tick is a one-cycle pulse on the terminal count.
- The top level holds the FSM, the toggle counter and the output registers.
- The top level instantiates tick_prescaler and exposes hex1/hex0 for two seven_segment instances.

Test Plan:
All scenarios use TICK_DIV=4 and BLINK_TOGGLES=4.
1. Reset, then idle for 10 cycles -> hex1=E, hex0=E, busy=0 throughout. Assert rst_n=0 asynchronously mid-cycle -> outputs go blank before the next edge.
2. load, player=2 -> one cycle later hex1=F, hex0=2. Then load, player=3 -> no change. Then load, player=1 -> hex0=1.
3. From SHOW with player 1, pulse win -> next edge blank and busy=1. Display then toggles every 4 cycles: shown, blank, shown. On the 4th tick (16 cycles after entry) -> HOLD: shown (F,1), busy=0.
4. During BLINK, pulse load with player=2 -> ignored: blink sequence and hex0 unchanged. Then pulse clear mid-blink -> next edge IDLE, blank, busy=0, tick counter held at 0.
5. Same-cycle strobes:
   - load(player=0) and clear together in SHOW -> IDLE.
   - win and load(player=2) together in SHOW -> BLINK with player unchanged.
6. From HOLD: win -> ignored. load with player=0 -> SHOW with hex1=F, hex0=0. Then clear followed by win -> stays IDLE, blank.
